// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the execute stage and a word-organised data memory.
// Optional macro LSU_MISALIGN_SPLIT_EN: split boundary-crossing accesses into two transactions.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request; late mem_ack is ignored here
// ISSUE0 | one-cycle mem_req for the first (or only) word
// WAIT0  | waiting for the first word's ack, with timeout
// ISSUE1 | one-cycle mem_req for the second word of a split access
// WAIT1  | waiting for the second word's ack, with timeout
// RESP   | one-cycle rsp_valid pulse
module lsu_mem_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  state_t state, state_nxt;

  logic             wr_q;
  logic [2:0]       ctrl_q;
  logic [1:0]       off_q;
  logic             split_q;
  logic [3:0]       be_hi_q;
  logic [31:0]      wdata_hi_q;
  logic [31:0]      rd0_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]  size_m;
  logic        ctrl_ok;
  logic        misalign;
  logic        reject;
  logic [7:0]  be8;
  logic [31:0] wd_sz;
  logic [63:0] wd64;
  logic        timeout_hit;
  logic [63:0] rd_pair;
  logic [31:0] rd_lo;
  logic [31:0] ld_ext;

  // Request decode: lane mask and data shifted across an 8-byte window so the
  // upper half directly gives the second word of a boundary-crossing access.
  always_comb begin
    size_m = 4'b0000;
    case (req_ctrl[1:0])
      2'b00:   size_m = 4'b0001;
      2'b01:   size_m = 4'b0011;
      2'b10:   size_m = 4'b1111;
      default: size_m = 4'b0000;
    endcase
    ctrl_ok  = (req_ctrl != 3'b011) && (req_ctrl[2:1] != 2'b11);
    misalign = ((req_ctrl[1:0] == 2'b01) && req_addr[0]) ||
               ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    reject   = !ctrl_ok || (misalign && !SPLIT_EN);
    be8      = {4'b0000, size_m} << req_addr[1:0];
    wd_sz    = req_wdata & {{8{size_m[3]}}, {8{size_m[2]}}, {8{size_m[1]}}, {8{size_m[0]}}};
    wd64     = {32'h0, wd_sz} << {req_addr[1:0], 3'b000};
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    rd_pair = (state == WAIT1) ? {mem_rdata, rd0_q} : {32'h0, mem_rdata};
    rd_lo   = 32'(rd_pair >> {off_q, 3'b000});
    ld_ext  = 32'h0;
    case (ctrl_q)
      3'b000:  ld_ext = {{24{rd_lo[7]}}, rd_lo[7:0]};
      3'b001:  ld_ext = {{16{rd_lo[15]}}, rd_lo[15:0]};
      3'b010:  ld_ext = rd_lo;
      3'b100:  ld_ext = {24'h0, rd_lo[7:0]};
      3'b101:  ld_ext = {16'h0, rd_lo[15:0]};
      default: ld_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = reject ? RESP : ISSUE0;
      end
      ISSUE0: begin
        mem_req   = 1'b1;
        state_nxt = WAIT0;
      end
      WAIT0: begin
        if (mem_ack)          state_nxt = split_q ? ISSUE1 : RESP;
        else if (timeout_hit) state_nxt = RESP;
      end
      ISSUE1: begin
        mem_req   = 1'b1;
        state_nxt = WAIT1;
      end
      WAIT1: begin
        if (mem_ack || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      ctrl_q     <= 3'b000;
      off_q      <= 2'b00;
      split_q    <= 1'b0;
      be_hi_q    <= 4'b0000;
      wdata_hi_q <= 32'h0;
      rd0_q      <= 32'h0;
      cnt_q      <= '0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'h0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q       <= req_wr;
            ctrl_q     <= req_ctrl;
            off_q      <= req_addr[1:0];
            split_q    <= (be8[7:4] != 4'b0000);
            be_hi_q    <= be8[7:4];
            wdata_hi_q <= wd64[63:32];
            mem_we     <= req_wr;
            mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be     <= be8[3:0];
            mem_wdata  <= wd64[31:0];
            if (reject) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        ISSUE0, ISSUE1: cnt_q <= '0;
        WAIT0: begin
          if (mem_ack) begin
            rd0_q <= mem_rdata;
            if (split_q) begin
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_be    <= be_hi_q;
              mem_wdata <= wdata_hi_q;
            end else begin
              rsp_err   <= 1'b0;
              rsp_rdata <= wr_q ? 32'h0 : ld_ext;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (timeout_hit) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        WAIT1: begin
          if (mem_ack) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= wr_q ? 32'h0 : ld_ext;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (timeout_hit) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed table-driven bench for lsu_mem_initiator, with hand sequences for
// the timeout/late-ack and reset-mid-transaction cases.
module tb_lsu_mem_initiator;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  lsu_mem_initiator #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          lat;     // 0 = never ack
    int          nreq;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] wd0;
    logic        err;
    logic [31:0] rdata;
    int          rsp_at;  // cycles after the acceptance cycle
  } vec_t;

  vec_t vt[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input string nm);
    int cnt_ack;
    int nreq;
    int rsp_at;
    logic [31:0] a0, a1, wd0;
    logic [3:0]  be0, be1;
    logic        we0, err;
    logic [31:0] rd;
    cnt_ack = 0; nreq = 0; rsp_at = -1;
    a0 = 0; a1 = 0; wd0 = 0; be0 = 0; be1 = 0; we0 = 0; err = 0; rd = 0;
    @(negedge clk);
    check({nm, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_wr = v.wr; req_ctrl = v.ctrl; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 60 && rsp_at < 0; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cnt_ack > 0) begin
        cnt_ack--;
        if (cnt_ack == 0) begin
          mem_ack = 1'b1;
          mem_rdata = (nreq == 1) ? v.rd0 : v.rd1;
        end
      end
      if (mem_req) begin
        nreq++;
        if (nreq == 1) begin a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we; end
        else begin a1 = mem_addr; be1 = mem_be; end
        cnt_ack = v.lat;
      end
      if (rsp_valid) begin
        rsp_at = k + 1;
        err = rsp_err;
        rd = rsp_rdata;
      end
    end
    mem_ack = 1'b0;
    check({nm, "_rsp_at"}, rsp_at, v.rsp_at);
    check({nm, "_nreq"}, nreq, v.nreq);
    check({nm, "_err"}, {31'h0, err}, {31'h0, v.err});
    check({nm, "_rdata"}, rd, v.rdata);
    if (v.nreq >= 1) begin
      check({nm, "_addr"}, a0, v.a0);
      check({nm, "_be"}, {28'h0, be0}, {28'h0, v.be0});
      check({nm, "_wdata"}, wd0, v.wd0);
      check({nm, "_we"}, {31'h0, we0}, {31'h0, v.wr});
    end
    if (v.nreq >= 2) begin
      check({nm, "_addr1"}, a1, v.a0 + 32'h4);
      check({nm, "_be1"}, {28'h0, be1}, {28'h0, v.be1});
    end
    @(negedge clk);
    check({nm, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
    check({nm, "_hold"}, rsp_rdata, v.rdata);
  endtask

  initial begin
    vt[0]  = '{1'b1, 3'b000, 32'h103, 32'hA5, 32'h0, 32'h0, 1, 1, 32'h100, 4'b1000, 4'b0, 32'hA500_0000, 1'b0, 32'h0, 3};
    vt[1]  = '{1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_1234, 32'h0, 2, 1, 32'h200, 4'b1100, 4'b0, 32'h0, 1'b0, 32'hFFFF_8001, 4};
    vt[2]  = '{1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_1234, 32'h0, 1, 1, 32'h200, 4'b1100, 4'b0, 32'h0, 1'b0, 32'h0000_8001, 3};
    vt[3]  = '{1'b0, 3'b000, 32'h105, 32'h0, 32'h1234_F678, 32'h0, 1, 1, 32'h104, 4'b0010, 4'b0, 32'h0, 1'b0, 32'hFFFF_FFF6, 3};
    vt[4]  = '{1'b0, 3'b100, 32'h107, 32'h0, 32'h9A00_0000, 32'h0, 3, 1, 32'h104, 4'b1000, 4'b0, 32'h0, 1'b0, 32'h0000_009A, 5};
    vt[5]  = '{1'b1, 3'b001, 32'h10A, 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 1, 32'h108, 4'b1100, 4'b0, 32'hBEEF_0000, 1'b0, 32'h0, 3};
    vt[6]  = '{1'b1, 3'b010, 32'h20C, 32'h1234_5678, 32'h0, 32'h0, 2, 1, 32'h20C, 4'b1111, 4'b0, 32'h1234_5678, 1'b0, 32'h0, 4};
    vt[7]  = '{1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 32'h0, 1, 1, 32'h300, 4'b1111, 4'b0, 32'h0, 1'b0, 32'hCAFE_F00D, 3};
    vt[8]  = '{1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0, 4'b0, 32'h0, 1'b1, 32'h0, 1};
    vt[9]  = '{1'b1, 3'b111, 32'h104, 32'h55, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0, 4'b0, 32'h0, 1'b1, 32'h0, 1};
    vt[10] = '{1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h0, 0, 1, 32'h300, 4'b1111, 4'b0, 32'h0, 1'b1, 32'h0, TO + 2};
`ifdef LSU_MISALIGN_SPLIT_EN
    vt[11] = '{1'b0, 3'b010, 32'h401, 32'h0, 32'h4433_2211, 32'h8877_6655, 1, 2, 32'h400, 4'b1110, 4'b0001, 32'h0, 1'b0, 32'h5544_3322, 5};
    vt[12] = '{1'b0, 3'b001, 32'h103, 32'h0, 32'hAB11_2233, 32'h4455_6680, 2, 2, 32'h100, 4'b1000, 4'b0001, 32'h0, 1'b0, 32'hFFFF_80AB, 7};
`else
    vt[11] = '{1'b0, 3'b010, 32'h401, 32'h0, 32'h4433_2211, 32'h8877_6655, 1, 0, 32'h0, 4'b0, 4'b0, 32'h0, 1'b1, 32'h0, 1};
    vt[12] = '{1'b0, 3'b001, 32'h103, 32'h0, 32'hAB11_2233, 32'h4455_6680, 2, 0, 32'h0, 4'b0, 4'b0, 32'h0, 1'b1, 32'h0, 1};
`endif

    #2;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) do_op(vt[i], $sformatf("v%0d", i));

    // Late ack arriving in IDLE after the timeout response.
    mem_rdata = 32'h1111_1111;
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_ack_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    mem_ack = 1'b0;

    // Reset asserted while waiting for the first ack.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_ctrl = 3'b010; req_addr = 32'h300; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wait0_ready", {31'h0, req_ready}, 32'h0);
    check("wait0_mem_req", {31'h0, mem_req}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midrst_mem_be", {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    mem_ack = 1'b0;
    do_op('{1'b1, 3'b001, 32'h502, 32'h0000_BEEF, 32'h0, 32'h0, 1, 1, 32'h500, 4'b1100, 4'b0, 32'hBEEF_0000, 1'b0, 32'h0, 3}, "post_rst_store");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that sits between the RISC-V execute stage and the word-organised data memory.
- Accepts one load/store request at a time, qualified by funct3 (the same dmctrl encoding used by the data memory).
- Drives word-aligned memory transactions with byte enables and aligned store data.
- Sign/zero-extends the returned load data and reports a single-cycle response with an error flag.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles to wait for mem_ack per memory transaction before aborting with error (>=2).
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_wr  in  1  1=store, 0=load
- req_ctrl  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  error qualifier, valid with rsp_valid
- rsp_rdata  out  32  extended load data, valid with rsp_valid
- mem_req  out  1  one-cycle transaction strobe
- mem_we  out  1  write transaction
- mem_addr  out  ADDR_W  word address, bits[1:0]=00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  transaction complete
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0; timeout counter=0.
- Reset mid-transaction: abort with no response; any later mem_ack while in IDLE is ignored.

State machine:
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- req_ready=1 only in IDLE. On acceptance, latch wr, ctrl, addr, wdata; then go to ISSUE0, or RESP with rsp_err=1 (see errors).
- ISSUE0/ISSUE1: mem_req=1 for exactly one cycle, then go to WAIT0/WAIT1.
- WAIT: mem_ack is sampled only in WAIT states. It is never accepted in the same cycle as mem_req.
  - On ack: go to ISSUE1 if a second access is pending, else RESP.
- RESP: rsp_valid=1 for one cycle, then return to IDLE.
  - rsp_rdata=0 for stores and for errors.
  - rsp_err and rsp_rdata hold their values until the next response.

Lanes:
- Definitions: off=addr[1:0], size mask m = 1/3/F for byte/half/word, mem_addr = {addr[ADDR_W-1:2],2'b00}.
- Store: mem_be=(m<<off)[3:0]; mem_wdata=req_wdata<<(8*off). Unused lanes are don't-care and are driven 0.
- Load: data=mem_rdata>>(8*off), then for ctrl 000/001 sign-extend from bit 7/15, for ctrl 100/101 zero-extend, for ctrl 010 pass through.
- Load transactions drive mem_we=0 and mem_be set per the store rule; the memory may ignore be on reads.

Errors:
- Illegal ctrl (011, 110, 111): no memory transaction; RESP the cycle after acceptance with rsp_err=1.
- Misalignment: a half with addr[0]=1, or a word with off!=0. Behaviour is set by the optional feature.
- Timeout: counter clears on each ISSUE and increments in WAIT. When it reaches TIMEOUT_CYCLES without ack, go to RESP with rsp_err=1; remaining accesses are skipped.

Latency:
- Aligned access, accepted at cycle T, ack L cycles after mem_req (L>=1): mem_req at T+1, rsp_valid at T+L+2.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN
- Defined:
  - A misaligned access contained in one word (half at off=1) completes in a single transaction.
  - A boundary-crossing access (half off=3; word off=1..3) splits into two transactions: first at mem_addr with be=(m<<off)[3:0], second at mem_addr+4 with be=(m<<off)[7:4] and wdata=req_wdata>>(8*(4-off)).
  - Load bytes are merged from both words before extension. An error on either transaction sets rsp_err.
- Undefined: any misaligned access gets an error response the cycle after acceptance, with no memory transaction. ISSUE1/WAIT1 are unreachable.

Test Plan:
- Store byte ctrl=000, addr=0x103, wdata=0x000000A5, L=1 -> mem_addr=0x100, be=1000, mem_wdata=0xA5000000, rsp_err=0, rsp_valid 3 cycles after acceptance.
- Load half signed ctrl=001, addr=0x202, mem_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; same access with ctrl=101 -> 0x00008001.
- Load word addr=0x300, mem_ack withheld -> rsp_err=1 exactly TIMEOUT_CYCLES cycles after entering WAIT0; a late ack in IDLE causes no extra rsp_valid.
- Illegal ctrl=011 -> no mem_req, rsp_valid and rsp_err=1 the cycle after acceptance, rsp_rdata=0.
- Load word addr=0x401, words 0x400=0x44332211 and 0x404=0x88776655:
  - with LSU_MISALIGN_SPLIT_EN: two mem_req (be 1110, then 0001), rsp_rdata=0x55443322;
  - without it: rsp_err=1 and no mem_req.
- Assert rst_n=0 in WAIT0, release, then issue a new store -> no stale response; new store completes normally with correct be and data.
